// File: rtl/mul_cell_combiner.sv
// ============================================================================
//  Module   : mul_cell_combiner
//  Purpose  : Sums registered 16x16 partial products into the 32-bit low word
//             (and optionally the high word) of a 32x32 product. Two-stage
//             valid/ready pipeline with flush and destination tag.
//  Options  : MUL_COMB_HI_EN - also form the upper 32 bits from in_p4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_cell_combiner #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [31:0]      in_p4,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_lo,
    output logic [31:0]      out_hi,
    output logic [TAG_W-1:0] out_tag
);

    logic             a_valid;
    logic [31:0]      a_p1;
    logic [TAG_W-1:0] a_tag;
    logic             b_adv;
    logic             capture;
    logic             load_b;
    logic [31:0]      lo_next;

`ifdef MUL_COMB_HI_EN
    logic [32:0]      a_mid;
    logic [32:0]      mid_sum;
    logic [31:0]      a_p4;
    logic [63:0]      full_sum;
`else
    // Only the low half of the middle sum can reach the low word.
    logic [15:0]      a_mid;
    logic [15:0]      mid_sum;
    logic             unused_inputs;
`endif

    assign b_adv    = a_valid & (~out_valid | out_ready);
    assign in_ready = ~a_valid | b_adv;
    assign capture  = in_valid & in_ready & ~flush;
    assign load_b   = b_adv & ~flush;

`ifdef MUL_COMB_HI_EN
    assign mid_sum  = {1'b0, in_p2} + {1'b0, in_p3};
    assign full_sum = {a_p4, a_p1} + ({31'h0, a_mid} << 16);
    assign lo_next  = full_sum[31:0];
`else
    assign mid_sum       = in_p2[15:0] + in_p3[15:0];
    assign lo_next       = a_p1 + {a_mid, 16'h0};
    assign unused_inputs = ^{in_p4, in_p2[31:16], in_p3[31:16]};
`endif

    // Stage A
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
            a_p1    <= '0;
            a_mid   <= '0;
            a_tag   <= '0;
        end else begin
            if (flush)
                a_valid <= 1'b0;
            else if (capture)
                a_valid <= 1'b1;
            else if (b_adv)
                a_valid <= 1'b0;

            if (capture) begin
                a_p1  <= in_p1;
                a_mid <= mid_sum;
                a_tag <= in_tag;
            end
        end
    end

`ifdef MUL_COMB_HI_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            a_p4 <= '0;
        else if (capture)
            a_p4 <= in_p4;
    end
`endif

    // Stage B: data moves only when A hands over a live product
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_lo    <= '0;
            out_tag   <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (b_adv)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (load_b) begin
                out_lo  <= lo_next;
                out_tag <= a_tag;
            end
        end
    end

`ifdef MUL_COMB_HI_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            out_hi <= '0;
        else if (load_b)
            out_hi <= full_sum[63:32];
    end
`else
    assign out_hi = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_cell_combiner.sv
// Self-checking bench for mul_cell_combiner: directed cases plus a random
// operand/backpressure/flush stream checked against a queue-based model.
`default_nettype none

module tb_mul_cell_combiner;

    localparam int TAG_W = 5;
`ifdef MUL_COMB_HI_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_p1, in_p2, in_p3, in_p4;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_lo, out_hi;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    mul_cell_combiner #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_p4(in_p4),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo(out_lo), .out_hi(out_hi), .out_tag(out_tag)
    );

    typedef struct {
        logic [31:0]      lo;
        logic [31:0]      hi;
        logic [TAG_W-1:0] tag;
        bit               vis;
    } item_t;

    item_t       q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          started = 1'b0;
    logic [63:0] cur_prod;
    logic        exp_valid, exp_ready;
    item_t       new_item;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        in_p1    = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
        in_p2    = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
        in_p3    = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        in_p4    = {16'h0, a[31:16]} * {16'h0, b[31:16]};
        in_tag   = t;
        cur_prod = {32'h0, a} * {32'h0, b};
    endtask

    // Model: in-order queue of accepted products; an entry becomes visible at
    // the output one edge after acceptance; at most two products in flight.
    always @(negedge clk) begin
        if (started) begin
            exp_valid = (q.size() > 0) && q[0].vis;
            exp_ready = (q.size() < 2) || out_ready;
            check("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
            check("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
            if (exp_valid && out_valid) begin
                check("out_lo", out_lo, q[0].lo);
                check("out_hi", out_hi, q[0].hi);
                check("out_tag", {27'h0, out_tag}, {27'h0, q[0].tag});
            end
            if (!reset_n || flush) begin
                q.delete();
            end else begin
                if (exp_valid && out_ready)
                    void'(q.pop_front());
                foreach (q[i]) q[i].vis = 1'b1;
                if (in_valid && exp_ready) begin
                    new_item.lo  = cur_prod[31:0];
                    new_item.hi  = HI_EN ? cur_prod[63:32] : 32'h0;
                    new_item.tag = in_tag;
                    new_item.vis = 1'b0;
                    q.push_back(new_item);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n products; rnd selects random operands/handshakes/flush/reset,
    // otherwise tags 1..n with out_ready low during cycles 3-6.
    task automatic stream(input int n, input bit rnd);
        int sent = 0;
        int cyc = 0;
        bit pending = 1'b0;
        while ((sent < n || pending) && cyc < 20 * n + 50) begin
            if (!pending && sent < n) begin
                if (rnd)
                    set_ops($urandom, $urandom, TAG_W'($urandom));
                else
                    set_ops(32'h0001_2345 * (sent + 1), 32'hF00D_0003 + sent, TAG_W'(sent + 1));
                pending = 1'b1;
                sent++;
            end
            in_valid  = pending && (rnd ? ($urandom_range(0, 9) < 7) : 1'b1);
            out_ready = rnd ? ($urandom_range(0, 9) < 7) : !(cyc >= 3 && cyc <= 6);
            flush     = rnd && ($urandom_range(0, 99) == 0);
            reset_n   = !(rnd && ($urandom_range(0, 999) == 0));
            @(negedge clk);
            if (in_valid && (in_ready || flush || !reset_n))
                pending = 1'b0;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        check("stream_done", {31'h0, (pending || sent < n)}, 32'h0);
        repeat (4) step();
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_ops(32'h0, 32'h0, '0);
        step();
        started = 1'b1;
        step();
        reset_n = 1'b1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_lo", out_lo, 32'h0);
        check("rst_out_hi", out_hi, 32'h0);
        check("rst_out_tag", {27'h0, out_tag}, 32'h0);

        // small operands
        set_ops(32'h0001_0003, 32'h0002_0005, 5'd3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("t1_valid", {31'h0, out_valid}, 32'h1);
        check("t1_lo", out_lo, 32'h000B_000F);
        check("t1_hi", out_hi, HI_EN ? 32'h2 : 32'h0);
        check("t1_tag", {27'h0, out_tag}, 32'd3);

        // all-ones squared exercises the carry into the high word
        set_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("t2_lo", out_lo, 32'h0000_0001);
        check("t2_hi", out_hi, HI_EN ? 32'hFFFF_FFFE : 32'h0);
        check("t2_tag", {27'h0, out_tag}, 32'd7);
        step();

        stream(8, 1'b0);

        // flush with two in flight and a new input presented
        out_ready = 1'b0;
        set_ops(32'd5, 32'd7, 5'd9);
        in_valid = 1'b1;
        step();
        set_ops(32'd6, 32'd8, 5'd10);
        step();
        set_ops(32'd1, 32'd1, 5'd11);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_valid", {31'h0, out_valid}, 32'h0);
        check("t4_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        repeat (3) step();

        // reset while stalled with valid data
        out_ready = 1'b0;
        set_ops(32'h1234_5678, 32'h9ABC_DEF0, 5'd21);
        in_valid = 1'b1;
        step();
        set_ops(32'h0BAD_F00D, 32'h0000_0011, 5'd22);
        step();
        in_valid = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("t5_valid", {31'h0, out_valid}, 32'h0);
        check("t5_lo", out_lo, 32'h0);
        check("t5_hi", out_hi, 32'h0);
        check("t5_tag", {27'h0, out_tag}, 32'h0);
        check("t5_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        set_ops(32'h0001_0003, 32'h0002_0005, 5'd4);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("t5_after_lo", out_lo, 32'h000B_000F);
        check("t5_after_tag", {27'h0, out_tag}, 32'd4);
        step();

        stream(10000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
